// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared types and constants for the CPU memory-bus responder.
//   state_e   : responder FSM states (IDLE / WAIT / DONE)
//   op_e      : latched access type (read / write)
//   MAX_WAIT  : largest wait-state count the 4-bit counter can express
//   wait_load : counter preload value for a given wait-state parameter
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    // The counter is loaded with (wait states - 1) so that the access lands on
    // the edge where the counter is already zero. Out-of-range requests
    // saturate at MAX_WAIT rather than wrapping.
    function automatic logic [CNT_W-1:0] wait_load(input int ws);
        if (ws <= 0) begin
            return '0;
        end else if (ws > MAX_WAIT) begin
            return CNT_W'(MAX_WAIT - 1);
        end else begin
            return CNT_W'(ws - 1);
        end
    endfunction

endpackage

// File: rtl/mem_array_256x8.sv
// mem_array_256x8
// Single-port program/data store with synchronous write and registered read.
// The read register only updates on read cycles (en=1, we=0), so it holds the
// last read value across writes and idle cycles. Only the read register is
// cleared by srst; the array contents survive reset.
//   clk   : clock
//   srst  : synchronous active-high reset of the read register
//   en    : port enable
//   we    : write enable (qualified by en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module mem_array_256x8 #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_reg [0:(1<<AW)-1];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_reg[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (en && !we) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder for the CPU external bus. Accepts a read or write
// request in IDLE, inserts WAIT_STATES wait cycles, performs the access on
// the single-port store and pulses READY for one cycle in DONE. A host load
// port can preload the store whenever the responder is idle.
//   CLK, RST          : clock, synchronous active-high reset
//   MADDR, RD, WR     : CPU address and level-sensitive request strobes
//   WDATA             : CPU write data
//   RDATA             : read data, held between reads, cleared by reset
//   READY             : one-cycle completion pulse
//   BUSY              : high outside IDLE
//   ERR               : sticky flag, RD and WR seen together in IDLE
//   LD_EN, LD_ADDR,
//   LD_DATA           : host load strobe, address and data
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] MADDR,
    input  logic          RD,
    input  logic          WR,
    input  logic [DW-1:0] WDATA,
    output logic [DW-1:0] RDATA,
    output logic          READY,
    output logic          BUSY,
    output logic          ERR,
    input  logic          LD_EN,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_DATA
);

    // With no wait states the access is issued straight from the bus inputs
    // on the same edge that accepts the request.
    localparam bit              ZERO_WAIT = (WAIT_STATES <= 0);
    localparam logic [CNT_W-1:0] WS_LOAD  = wait_load(WAIT_STATES);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [AW-1:0]    addr_reg,  addr_next;
    logic [DW-1:0]    wdata_reg, wdata_next;
    op_e              op_reg,    op_next;
    logic             err_reg,   err_next;

    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_en_gated;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            op_reg    <= OP_RD;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            op_reg    <= op_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        op_next    = op_reg;
        err_next   = err_reg;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;

        case (state_reg)
            IDLE: begin
                if (LD_EN) begin
                    // Host load owns the port; a simultaneous CPU request is
                    // dropped and must still be present next cycle to start.
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = LD_ADDR;
                    mem_wdata = LD_DATA;
                end else if (RD && WR) begin
                    err_next = 1'b1;
                end else if (RD || WR) begin
                    addr_next  = MADDR;
                    wdata_next = WDATA;
                    op_next    = WR ? OP_WR : OP_RD;
                    if (ZERO_WAIT) begin
                        mem_en     = 1'b1;
                        mem_we     = WR;
                        mem_addr   = MADDR;
                        mem_wdata  = WDATA;
                        state_next = DONE;
                    end else begin
                        cnt_next   = WS_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    mem_en     = 1'b1;
                    mem_we     = (op_reg == OP_WR);
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset aborts any access that would otherwise commit on the same edge.
    assign mem_en_gated = mem_en && !RST;

    mem_array_256x8 #(
        .AW(AW),
        .DW(DW)
    ) u_mem (
        .clk   (CLK),
        .srst  (RST),
        .en    (mem_en_gated),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (RDATA)
    );

    assign READY = (state_reg == DONE);
    assign BUSY  = (state_reg != IDLE);
    assign ERR   = err_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
// Four responder instances with 0, 1, 3 and 20 (saturating to 15) wait
// states, each driven by its own set of inputs. A transaction-level model
// (memory image per instance plus expected read register) supplies every
// expected value; the READY cycle is derived from the wait-state count.
module tb_cpu_mem_responder;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_s;
    logic [NI-1:0] rd_s;
    logic [NI-1:0] wr_s;
    logic [NI-1:0] ld_en_s;
    logic [NI-1:0] ready_s;
    logic [NI-1:0] busy_s;
    logic [NI-1:0] err_s;
    logic [7:0]    maddr_s   [NI];
    logic [7:0]    wdata_s   [NI];
    logic [7:0]    ld_addr_s [NI];
    logic [7:0]    ld_data_s [NI];
    logic [7:0]    rdata_s   [NI];

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [7:0] model_mem [NI][256];
    bit         known     [NI][256];
    logic [7:0] exp_rdata [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            cpu_mem_responder #(
                .AW(8),
                .DW(8),
                .WAIT_STATES(gi == 0 ? 0 : gi == 1 ? 1 : gi == 2 ? 3 : 20)
            ) u_dut (
                .CLK     (clk),
                .RST     (rst_s[gi]),
                .MADDR   (maddr_s[gi]),
                .RD      (rd_s[gi]),
                .WR      (wr_s[gi]),
                .WDATA   (wdata_s[gi]),
                .RDATA   (rdata_s[gi]),
                .READY   (ready_s[gi]),
                .BUSY    (busy_s[gi]),
                .ERR     (err_s[gi]),
                .LD_EN   (ld_en_s[gi]),
                .LD_ADDR (ld_addr_s[gi]),
                .LD_DATA (ld_data_s[gi])
            );
        end
    endgenerate

    function automatic int ws_eff(input int k);
        int w;
        case (k)
            0:       w = 0;
            1:       w = 1;
            2:       w = 3;
            default: w = 20;
        endcase
        return (w > 15) ? 15 : w;
    endfunction

    task automatic host_load(input int k, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en_s[k]   = 1'b1;
        ld_addr_s[k] = a;
        ld_data_s[k] = d;
        @(negedge clk);
        ld_en_s[k] = 1'b0;
        model_mem[k][a] = d;
        known[k][a]     = 1'b1;
        $display("inst%0d LOAD  addr=%02h data=%02h", k, a, d);
    endtask

    // One CPU access: strobe for one cycle, expect BUSY through the access and
    // READY only in cycle ws+1, then check RDATA and the return to IDLE.
    task automatic access(input int k, input bit is_wr, input logic [7:0] a,
                          input logic [7:0] d, input string tag);
        int n;
        logic exp_ready;
        n = ws_eff(k) + 1;
        @(negedge clk);
        rd_s[k]    = !is_wr;
        wr_s[k]    = is_wr;
        maddr_s[k] = a;
        wdata_s[k] = d;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rd_s[k] = 1'b0;
                wr_s[k] = 1'b0;
            end
            exp_ready = (c == n);
            checks++;
            if (busy_s[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: actual=%b required=1", tag, c, busy_s[k]);
            end
            checks++;
            if (ready_s[k] !== exp_ready) begin
                errors++;
                $display("FAIL %s ready cycle %0d: actual=%b required=%b", tag, c, ready_s[k], exp_ready);
            end
        end
        if (is_wr) begin
            model_mem[k][a] = d;
            known[k][a]     = 1'b1;
        end else begin
            exp_rdata[k] = model_mem[k][a];
        end
        checks++;
        if (rdata_s[k] !== exp_rdata[k]) begin
            errors++;
            $display("FAIL %s rdata: actual=%02h required=%02h", tag, rdata_s[k], exp_rdata[k]);
        end
        @(negedge clk);
        checks++;
        if (ready_s[k] !== 1'b0 || busy_s[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after done: ready=%b busy=%b required 0/0", tag, ready_s[k], busy_s[k]);
        end
        $display("inst%0d %s addr=%02h wdata=%02h rdata=%02h (%s)", k, is_wr ? "WRITE" : "READ ",
                 a, d, rdata_s[k], tag);
    endtask

    task automatic test_reset();
        rst_s = '1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (rdata_s[k] !== 8'h00 || ready_s[k] !== 1'b0 || busy_s[k] !== 1'b0 || err_s[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: rdata=%02h ready=%b busy=%b err=%b required 00/0/0/0",
                         k, rdata_s[k], ready_s[k], busy_s[k], err_s[k]);
            end
            exp_rdata[k] = 8'h00;
        end
        rst_s = '0;
        $display("reset applied to all instances");
    endtask

    task automatic test_basic_read();
        host_load(1, 8'h10, 8'hA5);
        access(1, 1'b0, 8'h10, 8'h00, "basic_read");
        checks++;
        if (err_s[1] !== 1'b0) begin
            errors++;
            $display("FAIL basic_read err: actual=%b required=0", err_s[1]);
        end
    endtask

    task automatic test_zero_wait();
        access(0, 1'b1, 8'h20, 8'h3C, "zw_write");
        access(0, 1'b0, 8'h20, 8'h00, "zw_read");
    endtask

    task automatic test_err();
        @(negedge clk);
        rd_s[0] = 1'b1; wr_s[0] = 1'b1; maddr_s[0] = 8'h20; wdata_s[0] = 8'h77;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (err_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
                errors++;
                $display("FAIL err_set cycle %0d: err=%b busy=%b ready=%b required 1/0/0",
                         c, err_s[0], busy_s[0], ready_s[0]);
            end
        end
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        access(0, 1'b0, 8'h20, 8'h00, "err_no_write");
        checks++;
        if (err_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: actual=%b required=1", err_s[0]);
        end
        @(negedge clk);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        exp_rdata[0] = 8'h00;
        checks++;
        if (err_s[0] !== 1'b0 || rdata_s[0] !== 8'h00) begin
            errors++;
            $display("FAIL err_clear: err=%b rdata=%02h required 0/00", err_s[0], rdata_s[0]);
        end
        $display("inst0 ERR set by RD&WR, cleared by reset");
    endtask

    task automatic test_reset_mid_op();
        host_load(2, 8'h40, 8'h00);
        access(2, 1'b0, 8'h40, 8'h00, "pre_abort_read");
        @(negedge clk);
        wr_s[2] = 1'b1; maddr_s[2] = 8'h40; wdata_s[2] = 8'hFF;
        @(negedge clk);
        wr_s[2] = 1'b0;
        checks++;
        if (busy_s[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort busy before reset: actual=%b required=1", busy_s[2]);
        end
        @(negedge clk);
        rst_s[2] = 1'b1;
        @(negedge clk);
        rst_s[2] = 1'b0;
        exp_rdata[2] = 8'h00;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (ready_s[2] !== 1'b0 || busy_s[2] !== 1'b0) begin
                errors++;
                $display("FAIL abort idle %0d: ready=%b busy=%b required 0/0", c, ready_s[2], busy_s[2]);
            end
            @(negedge clk);
        end
        $display("inst2 write to 40 aborted by reset");
        access(2, 1'b0, 8'h40, 8'h00, "post_abort_read");
    endtask

    task automatic test_load_and_rd();
        int n;
        logic exp_ready;
        n = ws_eff(1) + 1;
        @(negedge clk);
        ld_en_s[1] = 1'b1; ld_addr_s[1] = 8'h55; ld_data_s[1] = 8'h3E;
        rd_s[1] = 1'b1; maddr_s[1] = 8'h55;
        @(negedge clk);
        checks++;
        if (busy_s[1] !== 1'b0 || ready_s[1] !== 1'b0) begin
            errors++;
            $display("FAIL load_rd ignored: busy=%b ready=%b required 0/0", busy_s[1], ready_s[1]);
        end
        ld_en_s[1] = 1'b0;
        model_mem[1][8'h55] = 8'h3E;
        known[1][8'h55]     = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) rd_s[1] = 1'b0;
            exp_ready = (c == n);
            checks++;
            if (ready_s[1] !== exp_ready || busy_s[1] !== 1'b1) begin
                errors++;
                $display("FAIL load_rd cycle %0d: ready=%b busy=%b required %b/1", c, ready_s[1], busy_s[1], exp_ready);
            end
        end
        exp_rdata[1] = 8'h3E;
        checks++;
        if (rdata_s[1] !== exp_rdata[1]) begin
            errors++;
            $display("FAIL load_rd rdata: actual=%02h required=%02h", rdata_s[1], exp_rdata[1]);
        end
        @(negedge clk);
        $display("inst1 LOAD+READ addr=55 rdata=%02h", rdata_s[1]);
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [2];
        logic exp_ready;
        addrs[0] = 8'hFE;
        addrs[1] = 8'hFF;
        host_load(1, 8'hFE, 8'($urandom));
        host_load(1, 8'hFF, 8'($urandom));
        @(negedge clk);
        rd_s[1] = 1'b1; maddr_s[1] = addrs[0];
        for (int i = 0; i < 2; i++) begin
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                exp_ready = (c == 2);
                checks++;
                if (ready_s[1] !== exp_ready) begin
                    errors++;
                    $display("FAIL b2b ready acc%0d cycle %0d: actual=%b required=%b", i, c, ready_s[1], exp_ready);
                end
                if (c == 2) begin
                    exp_rdata[1] = model_mem[1][addrs[i]];
                    checks++;
                    if (rdata_s[1] !== exp_rdata[1] || err_s[1] !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b rdata acc%0d: rdata=%02h err=%b required %02h/0",
                                 i, rdata_s[1], err_s[1], exp_rdata[1]);
                    end
                    $display("inst1 HELD READ addr=%02h rdata=%02h", addrs[i], rdata_s[1]);
                    maddr_s[1] = addrs[1];
                    if (i == 1) rd_s[1] = 1'b0;
                end
            end
        end
    endtask

    task automatic test_random();
        int k;
        int sel;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            k   = $urandom_range(0, NI - 1);
            sel = $urandom_range(0, 2);
            a   = 8'($urandom);
            d   = 8'($urandom);
            if (sel == 0) begin
                host_load(k, a, d);
            end else if (sel == 1 || !known[k][a]) begin
                access(k, 1'b1, a, d, "rand_write");
            end else begin
                access(k, 1'b0, a, 8'h00, "rand_read");
            end
        end
    endtask

    task automatic test_saturation();
        host_load(3, 8'h00, 8'h5A);
        access(3, 1'b0, 8'h00, 8'h00, "sat_read");
        access(3, 1'b1, 8'hFF, 8'hC3, "sat_write_wrap");
        access(3, 1'b0, 8'hFF, 8'h00, "sat_read_ff");
    endtask

    initial begin
        rst_s   = '1;
        rd_s    = '0;
        wr_s    = '0;
        ld_en_s = '0;
        for (int k = 0; k < NI; k++) begin
            maddr_s[k]   = '0;
            wdata_s[k]   = '0;
            ld_addr_s[k] = '0;
            ld_data_s[k] = '0;
            exp_rdata[k] = '0;
            for (int j = 0; j < 256; j++) begin
                known[k][j]     = 1'b0;
                model_mem[k][j] = '0;
            end
        end
        test_reset();
        test_basic_read();
        test_zero_wait();
        test_err();
        test_reset_mid_op();
        test_load_and_rd();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
